// File: rtl/inst_fetch.sv
// Instruction fetch: reads four little-endian bytes per word from a byte-wide memory port
// and offers the assembled word to the decoder. Optional JAL prediction under JAL_PREDICT_EN.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  output logic              mem_req_out,
  input  logic              mem_gnt_in,
  output logic [ADDR_W-1:0] mem_a_out,
  input  logic [7:0]        mem_din_in,
  input  logic              flush_in,
  input  logic [31:0]       flush_pc_in,
  output logic              inst_valid_out,
  input  logic              inst_ready_in,
  output logic [31:0]       inst_out,
  output logic [31:0]       inst_pc_out,
  output logic              inst_pred_out
);

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  issue_cnt_q, issue_cnt_d;
  logic [1:0]  ret_cnt_q, ret_cnt_d;
  logic        pending_q, pending_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;

  logic [31:0] addr_full;
  logic        req;
  logic        handshake;
  logic [31:0] next_pc;

  assign addr_full = pc_q + {29'b0, issue_cnt_q};
  // Outputs are forced quiet while reset is held, independent of the clock.
  assign req       = rst_in && rdy_in && (state_q == S_FETCH) && (issue_cnt_q < 3'd4);
  assign handshake = valid_q && inst_ready_in;

  assign mem_req_out    = req;
  assign mem_a_out      = (rst_in && state_q == S_FETCH) ? addr_full[ADDR_W-1:0] : '0;
  assign inst_valid_out = valid_q;
  assign inst_out       = inst_q;
  assign inst_pc_out    = inst_pc_q;

`ifdef JAL_PREDICT_EN
  logic        pred_q, pred_d;
  logic [31:0] jimm;

  assign jimm    = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
  assign next_pc = pred_q ? (inst_pc_q + jimm) : (pc_q + 32'd4);
  assign inst_pred_out = pred_q;
`else
  assign next_pc       = pc_q + 32'd4;
  assign inst_pred_out = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    pending_d   = 1'b0;
    valid_d     = valid_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
`ifdef JAL_PREDICT_EN
    pred_d      = pred_q;
`endif

    // Byte capture follows the grant by one cycle and ignores rdy_in.
    if (pending_q) begin
      case (ret_cnt_q)
        2'd0:    inst_d[7:0]   = mem_din_in;
        2'd1:    inst_d[15:8]  = mem_din_in;
        2'd2:    inst_d[23:16] = mem_din_in;
        default: inst_d[31:24] = mem_din_in;
      endcase
      ret_cnt_d = ret_cnt_q + 2'd1;
      if (ret_cnt_q == 2'd3) begin
        state_d     = S_HOLD;
        valid_d     = 1'b1;
        inst_pc_d   = pc_q;
        issue_cnt_d = 3'd0;
        ret_cnt_d   = 2'd0;
`ifdef JAL_PREDICT_EN
        pred_d      = (inst_d[6:0] == 7'b1101111);
`endif
      end
    end

    if (req && mem_gnt_in) begin
      issue_cnt_d = issue_cnt_q + 3'd1;
      pending_d   = 1'b1;
    end

    if (handshake) begin
      valid_d = 1'b0;
      pc_d    = next_pc;
      state_d = S_FETCH;
    end

    // Redirect overrides everything, including a same-edge handshake.
    if (flush_in) begin
      pc_d        = flush_pc_in & 32'hFFFF_FFFC;
      issue_cnt_d = 3'd0;
      ret_cnt_d   = 2'd0;
      pending_d   = 1'b0;
      valid_d     = 1'b0;
      state_d     = S_FETCH;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      issue_cnt_q <= 3'd0;
      ret_cnt_q   <= 2'd0;
      pending_q   <= 1'b0;
      valid_q     <= 1'b0;
      inst_q      <= 32'd0;
      inst_pc_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      pending_q   <= pending_d;
      valid_q     <= valid_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
    end
  end

`ifdef JAL_PREDICT_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) pred_q <= 1'b0;
    else         pred_q <= pred_d;
  end
`endif

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Producer side of the 32-bit instruction word consumed by the decoder.
- Reads four bytes per instruction, little-endian, from the byte-wide memory port behind the memory arbiter.
- Assembles the bytes into one word and offers it downstream with a valid/ready handshake, together with its PC.
- Handles pipeline redirects (branch/jump flush) from the backend.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset.
ADDR_W, 32, width of mem_a_out. Carries the low ADDR_W bits of the byte address.

Ports:
clk_in  input  1  clock; all state updates on rising edge.
rst_in  input  1  asynchronous, active-low reset.
rdy_in  input  1  global enable; 0 freezes FSM, PC and issue counter.
mem_req_out  output  1  byte read request to arbiter.
mem_gnt_in  input  1  arbiter grant for the current cycle's request.
mem_a_out  output  ADDR_W  byte address of current request.
mem_din_in  input  8  read byte, valid the cycle after a granted request.
flush_in  input  1  redirect request.
flush_pc_in  input  32  redirect target.
inst_valid_out  output  1  inst_out/inst_pc_out hold a complete word.
inst_ready_in  input  1  decoder accepts the word.
inst_out  output  32  assembled instruction word.
inst_pc_out  output  32  PC of inst_out.
inst_pred_out  output  1  next PC was predicted non-sequential (see Optional Feature).

Behaviour:
- Reset (rst_in=0, asynchronous):
  - pc=RESET_PC, state=FETCH, issue_cnt=0, ret_cnt=0, pending=0.
  - Outputs: mem_req_out=0, mem_a_out=0, inst_valid_out=0, inst_out=0, inst_pc_out=0, inst_pred_out=0.
- States:
  - FETCH: assembling a word.
  - HOLD: word valid, waiting for handshake.
- FETCH:
  - mem_req_out = rdy_in && issue_cnt<4.
  - mem_a_out = (pc + issue_cnt)[ADDR_W-1:0].
  - On an edge with mem_req_out && mem_gnt_in: issue_cnt++ and pending<=1 (else pending<=0).
  - Byte capture in the next cycle is NOT gated by rdy_in.
- Byte capture: when pending=1, mem_din_in is written to inst_out[8*ret_cnt +: 8] and ret_cnt++.
- Word complete: on the edge capturing byte 3:
  - state<=HOLD, inst_valid_out<=1, inst_pc_out<=pc.
  - Counters are cleared.
- Latency: with grants every cycle, requests occupy cycles t..t+3, bytes arrive t+1..t+4, inst_valid_out is high from t+5.
- HOLD:
  - mem_req_out=0.
  - inst_out, inst_pc_out and inst_pred_out are stable while inst_valid_out=1 && !inst_ready_in.
  - Handshake = edge with inst_valid_out && inst_ready_in. On it: inst_valid_out<=0, pc<=next_pc, state<=FETCH.
  - The first request for the next word is in the following cycle.
- next_pc: pc+4 modulo 2^32, so 0xFFFF_FFFC wraps to 0.
- No prefetch: at most one word is in progress.
- Grant gaps: the address advances only on granted cycles. Ungranted cycles repeat the same mem_a_out.
- Flush (highest priority, acts regardless of state and rdy_in):
  - pc<={flush_pc_in[31:2],2'b00}.
  - issue_cnt, ret_cnt and pending are cleared; inst_valid_out<=0; state<=FETCH.
  - A byte returning in the cycle after the flush edge is discarded.
- Flush and handshake on the same edge: flush wins for the PC. The word is treated as consumed.
- rdy_in=0 in HOLD: valid and data are held. A handshake still completes, because it is owned by the consumer.

Optional Feature:
Macro JAL_PREDICT_EN.
- Defined:
  - At word completion, if the assembled opcode [6:0]==7'b1101111, inst_pred_out<=1.
  - At handshake, next_pc = inst_pc_out + sign-extended J-immediate {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}, modulo 2^32.
  - Otherwise behaviour is identical to undefined.
- Undefined: next_pc always pc+4 and inst_pred_out tied 0.

Test Plan:
1. Reset release, RESET_PC=0, bytes 13 05 50 00 at 0..3, grant held 1 -> mem_a_out 0,1,2,3 in four consecutive cycles; inst_valid_out=1 on the fifth cycle after the first request; inst_out=32'h00500513, inst_pc_out=0.
2. inst_ready_in held 0 for 3 cycles after valid -> inst_out stable, mem_req_out=0; after handshake, next request mem_a_out=4.
3. mem_gnt_in alternating 1/0 -> each address presented until granted; word 32'h00500513 still assembled correctly.
4. flush_in with flush_pc_in=0x100 after two bytes received and one in flight -> in-flight byte dropped; requests 0x100..0x103; inst_pc_out=0x100.
5. flush_in with flush_pc_in=0x102 on the handshake edge -> no extra word emitted; fetch restarts at 0x100.
6. Word 32'h0080006F at 0x10 -> with JAL_PREDICT_EN, inst_pred_out=1 and next fetch starts at 0x18; without it, inst_pred_out=0 and next fetch starts at 0x14.
